regfile_wb_ctrl: RTL

REGFILE_WB_CTRL -- requirements
Module: regfile_wb_ctrl

---
 rtl/regfile_pkg.sv | 35 +++
 rtl/rr_arbiter2.sv | 49 ++++
 rtl/regfile_wb_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared destination codes, writable-code mask and requester
//               encoding for the register-file writeback controller.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int DEST_W = 5;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

    // Destination code landmarks: two writable windows, everything else is
    // non-writable (including the hard-wired zero code).
    localparam logic [DEST_W-1:0] DEST_ZERO    = 5'b00000;
    localparam logic [DEST_W-1:0] DEST_WA_LO   = 5'b01000;
    localparam logic [DEST_W-1:0] DEST_WA_HI   = 5'b01111;
    localparam logic [DEST_W-1:0] DEST_WB_LO   = 5'b10001;
    localparam logic [DEST_W-1:0] DEST_WB_HI   = 5'b10111;

    // Bit n set means code n is writable: codes 8..15 and 17..23.
    localparam logic [31:0] WRITABLE_MASK = 32'h00FE_FF00;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_MEM = 1'b1
    } req_e;

    function automatic logic is_writable(input logic [DEST_W-1:0] code);
        return WRITABLE_MASK[code];
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-way round-robin arbiter between the ALU and load-unit
//               writeback requesters. Grants are combinational; the
//               last-grant record advances only when a transfer happens.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2
    import regfile_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic alu_valid,
    input  logic mem_valid,
    output logic alu_grant,
    output logic mem_grant
);

    req_e r_last_grant;
    logic w_pick_mem;

    // Choose the requester: sole requester wins, on conflict the one not served last.
    always_comb begin
        w_pick_mem = 1'b0;
        if (alu_valid && mem_valid) begin
            w_pick_mem = (r_last_grant == REQ_ALU);
        end else begin
            w_pick_mem = mem_valid;
        end
    end

    // Grants are forced low while reset is held so no handshake can complete.
    assign alu_grant = rst_n && alu_valid && !w_pick_mem;
    assign mem_grant = rst_n && mem_valid &&  w_pick_mem;

    // Remember who was served; reset to MEM so the ALU wins the first conflict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= REQ_MEM;
        end else if (alu_grant) begin
            r_last_grant <= REQ_ALU;
        end else if (mem_grant) begin
            r_last_grant <= REQ_MEM;
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_ctrl
// Description : Register-file writeback controller. Arbitrates ALU and load
//               writebacks onto one registered write port, tracks pending
//               destinations in a scoreboard for issue hazard stalls, and
//               counts committed writes.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_ctrl
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [4:0]        alu_dest,
    input  logic [31:0]       alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [4:0]        mem_dest,
    input  logic [31:0]       mem_data,
    output logic              rf_we,
    output logic [4:0]        rf_waddr,
    output logic [31:0]       rf_wdata,
    input  logic              issue_valid,
    input  logic [4:0]        issue_dest,
    input  logic [4:0]        issue_src1,
    input  logic [4:0]        issue_src2,
    output logic              issue_stall,
    input  logic              flush,
    output logic [31:0]       pending,
    output logic [15:0]       wb_count
);

    logic              r_rf_we;
    logic [4:0]        r_rf_waddr;
    logic [31:0]       r_rf_wdata;
    logic [31:0]       r_pending;
    logic [15:0]       r_wb_count;

    logic              w_xfer;
    logic [4:0]        w_xfer_dest;
    logic [31:0]       w_xfer_data;
    logic              w_issue_set;
    logic [31:0]       w_set_vec;
    logic [31:0]       w_clr_vec;
    logic [31:0]       w_pending_nxt;

    rr_arbiter2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_valid (alu_valid),
        .mem_valid (mem_valid),
        .alu_grant (alu_ready),
        .mem_grant (mem_ready)
    );

    // Mux the winning requester onto the transfer path.
    always_comb begin
        w_xfer      = alu_ready || mem_ready;
        w_xfer_dest = mem_ready ? mem_dest : alu_dest;
        w_xfer_data = mem_ready ? mem_data : alu_data;
    end

    // Hazard check: sources pending, or a writable destination still pending.
    always_comb begin
        issue_stall = issue_valid &&
                      (r_pending[issue_src1] || r_pending[issue_src2] ||
                       (is_writable(issue_dest) && r_pending[issue_dest]));
    end

    // Scoreboard next state: clear on commit, set on issue (set wins), flush overrides all.
    always_comb begin
        w_issue_set   = issue_valid && !issue_stall && is_writable(issue_dest);
        w_set_vec     = w_issue_set ? (32'd1 << issue_dest) : 32'd0;
        w_clr_vec     = r_rf_we     ? (32'd1 << r_rf_waddr) : 32'd0;
        w_pending_nxt = flush ? 32'd0
                              : (((r_pending & ~w_clr_vec) | w_set_vec) & WRITABLE_MASK);
    end

    // Write port: pulse for one cycle after a writable transfer, otherwise hold address/data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
        end else begin
            r_rf_we <= w_xfer && is_writable(w_xfer_dest);
            if (w_xfer && is_writable(w_xfer_dest)) begin
                r_rf_waddr <= w_xfer_dest;
                r_rf_wdata <= w_xfer_data;
            end
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    // Committed-write counter, saturating at all ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_count <= '0;
        end else if (r_rf_we && (r_wb_count != 16'hFFFF)) begin
            r_wb_count <= r_wb_count + 16'd1;
        end
    end

    assign rf_we    = r_rf_we;
    assign rf_waddr = r_rf_waddr;
    assign rf_wdata = r_rf_wdata;
    assign pending  = r_pending;
    assign wb_count = r_wb_count;

endmodule
`default_nettype wire
